// File: rtl/wb_sdram_arb2.sv
// Two-master Wishbone arbiter in front of the SDRAM controller's slave port.
// Round-robin grant per cyc_i, gated by SDRAM init, with a stall watchdog that errors hung transfers.
module wb_sdram_arb2 #(
    parameter int DW      = 32,
    parameter int AW      = 26,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sdr_init_done,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [AW-1:0]     m0_addr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [2:0]        m0_cti_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [AW-1:0]     m1_addr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [2:0]        m1_cti_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [AW-1:0]     s_addr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic [2:0]        s_cti_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,

    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT - 1);

    state_t          state_reg, state_next;
    logic            last_gnt_reg, last_gnt_next;
    logic [TO_W-1:0] wdog_reg, wdog_next;

    logic            stb_raw;
    logic            stall;
    logic            timeout;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg    <= IDLE;
            last_gnt_reg <= 1'b1;
            wdog_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            last_gnt_reg <= last_gnt_next;
            wdog_reg     <= wdog_next;
        end
    end

    // Grant selection; a finishing owner hands straight to a waiting peer with no idle gap.
    always_comb begin
        state_next    = state_reg;
        last_gnt_next = last_gnt_reg;
        case (state_reg)
            IDLE: begin
                if (sdr_init_done) begin
                    if (m0_cyc_i && m1_cyc_i)
                        state_next = last_gnt_reg ? GNT0 : GNT1;
                    else if (m0_cyc_i)
                        state_next = GNT0;
                    else if (m1_cyc_i)
                        state_next = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    last_gnt_next = 1'b0;
                    state_next    = (m1_cyc_i && sdr_init_done) ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    last_gnt_next = 1'b1;
                    state_next    = (m0_cyc_i && sdr_init_done) ? GNT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        stb_raw  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = 3'b000;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        case (state_reg)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                stb_raw  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_addr_o = m0_addr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_cti_o  = m0_cti_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                stb_raw  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_addr_o = m1_addr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_cti_o  = m1_cti_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
            end
            default: ;
        endcase
    end

    // An ack in the same cycle as the timeout wins: the access completed, so no error.
    assign stall    = stb_raw && !s_ack_i;
    assign timeout  = stall && (wdog_reg == WDOG_LAST);
    assign s_stb_o  = stb_raw && !timeout;
    assign m0_err_o = timeout && (state_reg == GNT0);
    assign m1_err_o = timeout && (state_reg == GNT1);

    always_comb begin
        wdog_next = wdog_reg;
        if ((state_next != state_reg) || s_ack_i || timeout)
            wdog_next = '0;
        else if (stall)
            wdog_next = wdog_reg + 1'b1;
    end

    assign grant_o = {state_reg == GNT1, state_reg == GNT0};

endmodule
